// File: rtl/mnist_frame_buffer_if.sv
// Signal bundle between the camera-side capture path, the frame buffer and mnist_process.
// Both streams are valid-only: a beat transfers on every rising edge where its valid is high; there is no ready/backpressure.
interface mnist_frame_buffer_if;
    logic       frame_start;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       load_start;
    logic       mnist_data_valid;
    logic [7:0] mnist_data;
    logic       busy;
    logic [2:0] state_dbg;

    modport master (
        output frame_start, pix_valid, pix_data,
        input  load_start, mnist_data_valid, mnist_data, busy, state_dbg
    );

    modport slave (
        input  frame_start, pix_valid, pix_data,
        output load_start, mnist_data_valid, mnist_data, busy, state_dbg
    );
endinterface

// File: rtl/mnist_frame_buffer.sv
// Single 28x28 frame buffer: captures one scaled camera frame, then replays it to mnist_process
// as 28 row bursts of 28 pixels behind a load_start pulse. Capture and playback never overlap.
module mnist_frame_buffer #(
    parameter int PRE_WAIT    = 2,
    parameter int ROW_GAP     = 4,
    parameter int COOL_CYCLES = 40000,
    parameter int INVERT      = 0
) (
    input  logic              cmos_pclk,
    input  logic              rst_n,
    mnist_frame_buffer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        START   = 3'd2,
        PRE     = 3'd3,
        ROW     = 3'd4,
        GAP     = 3'd5,
        COOL    = 3'd6
    } state_t;

    localparam logic [9:0]  LAST_ADDR = 10'd783;
    localparam logic [4:0]  LAST_IDX  = 5'd27;
    localparam logic [15:0] PRE_LAST  = 16'(PRE_WAIT - 1);
    localparam logic [15:0] GAP_LAST  = 16'(ROW_GAP - 1);
    localparam logic [15:0] COOL_LAST = 16'(COOL_CYCLES - 1);

    state_t      state;
    logic [9:0]  wr_cnt;
    logic [9:0]  rd_addr;
    logic [4:0]  col;
    logic [4:0]  row;
    logic [15:0] cnt;
    logic        load_start_q;
    logic        valid_q;
    logic [7:0]  data_q;
    logic        busy_q;

    logic [7:0]  mem [0:783];
    logic        wr_en;
    logic [9:0]  wr_addr;

    // A frame_start always rewinds to address 0, so a coincident pixel lands there.
    always_comb begin
        wr_en   = rst_n && bus.pix_valid &&
                  (state == CAPTURE || (state == IDLE && bus.frame_start));
        wr_addr = bus.frame_start ? 10'd0 : wr_cnt;
    end

    always_ff @(posedge cmos_pclk) begin
        if (wr_en) mem[wr_addr] <= bus.pix_data;
    end

    always_ff @(posedge cmos_pclk) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_cnt       <= '0;
            rd_addr      <= '0;
            col          <= '0;
            row          <= '0;
            cnt          <= '0;
            load_start_q <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            busy_q       <= 1'b0;
        end else begin
            load_start_q <= 1'b0;
            valid_q      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.frame_start) begin
                        state  <= CAPTURE;
                        wr_cnt <= bus.pix_valid ? 10'd1 : 10'd0;
                    end
                end
                CAPTURE: begin
                    if (bus.frame_start) begin
                        wr_cnt <= bus.pix_valid ? 10'd1 : 10'd0;
                    end else if (bus.pix_valid) begin
                        if (wr_cnt == LAST_ADDR) begin
                            state        <= START;
                            wr_cnt       <= '0;
                            load_start_q <= 1'b1;
                            busy_q       <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + 10'd1;
                        end
                    end
                end
                START: begin
                    state <= PRE;
                    cnt   <= '0;
                end
                PRE: begin
                    if (cnt == PRE_LAST) begin
                        state   <= ROW;
                        cnt     <= '0;
                        rd_addr <= '0;
                        col     <= '0;
                        row     <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ROW: begin
                    // Synchronous read: the output register is the one cycle of read latency.
                    valid_q <= 1'b1;
                    data_q  <= (INVERT != 0) ? ~mem[rd_addr] : mem[rd_addr];
                    rd_addr <= rd_addr + 10'd1;
                    if (col == LAST_IDX) begin
                        col <= '0;
                        cnt <= '0;
                        if (row == LAST_IDX) begin
                            state <= COOL;
                        end else begin
                            row   <= row + 5'd1;
                            state <= GAP;
                        end
                    end else begin
                        col <= col + 5'd1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= ROW;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                COOL: begin
                    if (cnt == COOL_LAST) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.load_start       = load_start_q;
    assign bus.mnist_data_valid = valid_q;
    assign bus.mnist_data       = data_q;
    assign bus.busy             = busy_q;
    assign bus.state_dbg        = state;

endmodule
